// File: rtl/montgomery_exp.sv
// Left-to-right binary modular exponentiation that drives an external
// Montgomery multiplier. Operands are converted into the Montgomery domain,
// one square (and an optional multiply) runs per exponent bit, MSB first, and
// the accumulator is then converted back. Each multiplication is a
// start/done handshake with the multiplier.
module montgomery_exp #(
  parameter int N      = 1024,
  parameter int E_BITS = 1024,
  parameter int T_W    = 11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [N-1:0]      in_x,
  input  logic [E_BITS-1:0] in_e,
  input  logic [T_W-1:0]    in_t,
  input  logic [N-1:0]      in_m,
  input  logic [N-1:0]      in_r,
  input  logic [N-1:0]      in_r2,
  output logic [N-1:0]      result,
  output logic              done,
  output logic              mm_start,
  output logic [N-1:0]      mm_a,
  output logic [N-1:0]      mm_b,
  output logic [N-1:0]      mm_m,
  input  logic [N-1:0]      mm_result,
  input  logic              mm_done
);

  localparam int IW = (E_BITS > 1) ? $clog2(E_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOMONT,
    S_SQUARE,
    S_MULT,
    S_FROMMONT
  } state_t;

  state_t              state_q, state_d;
  logic [E_BITS-1:0]   e_q, e_d;
  logic [IW-1:0]       i_q, i_d;
  logic                t_nz_q, t_nz_d;
  logic [N-1:0]        acc_q, acc_d;
  logic [N-1:0]        xt_q, xt_d;
  logic [N-1:0]        result_d, mm_a_d, mm_b_d, mm_m_d;
  logic                done_d, mm_start_d;

  logic [T_W-1:0]      t_sat;
  logic                mm_ack;
  logic                last_bit;
  logic [N-1:0]        acc_new;

  // Next-state, datapath and handshake decisions for the exponentiation FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    e_d        = e_q;
    i_d        = i_q;
    t_nz_d     = t_nz_q;
    acc_d      = acc_q;
    xt_d       = xt_q;
    result_d   = result;
    mm_a_d     = mm_a;
    mm_b_d     = mm_b;
    mm_m_d     = mm_m;
    done_d     = 1'b0;
    mm_start_d = 1'b0;

    // Exponent lengths beyond the exponent register are clamped to it.
    t_sat    = (in_t > T_W'(E_BITS)) ? T_W'(E_BITS) : in_t;
    // A completion only counts while waiting, never in the launch cycle.
    mm_ack   = (state_q != S_IDLE) && !mm_start && mm_done;
    last_bit = (i_q == '0);
    // TOMONT produces xt; every later step produces the new accumulator.
    acc_new  = (state_q == S_TOMONT) ? acc_q : mm_result;

    case (state_q)
      S_IDLE: begin
        if (start && !done) begin
          state_d    = S_TOMONT;
          e_d        = in_e;
          i_d        = IW'(t_sat - T_W'(1));
          t_nz_d     = (t_sat != '0);
          acc_d      = in_r;
          xt_d       = '0;
          mm_start_d = 1'b1;
          mm_a_d     = in_x;
          mm_b_d     = in_r2;
          mm_m_d     = in_m;
        end
      end
      S_TOMONT: begin
        if (mm_ack) begin
          xt_d    = mm_result;
          state_d = t_nz_q ? S_SQUARE : S_FROMMONT;
        end
      end
      S_SQUARE: begin
        if (mm_ack) begin
          if (e_q[i_q]) begin
            state_d = S_MULT;
          end else if (!last_bit) begin
            i_d     = i_q - IW'(1);
            state_d = S_SQUARE;
          end else begin
            state_d = S_FROMMONT;
          end
        end
      end
      S_MULT: begin
        if (mm_ack) begin
          if (!last_bit) begin
            i_d     = i_q - IW'(1);
            state_d = S_SQUARE;
          end else begin
            state_d = S_FROMMONT;
          end
        end
      end
      S_FROMMONT: begin
        if (mm_ack) begin
          result_d = mm_result;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Launch the next multiplication in the cycle right after a completion.
    if (mm_ack && (state_q != S_FROMMONT)) begin
      acc_d      = acc_new;
      mm_start_d = 1'b1;
      mm_a_d     = acc_new;
      case (state_d)
        S_MULT:     mm_b_d = xt_q;
        S_FROMMONT: mm_b_d = N'(1);
        default:    mm_b_d = acc_new;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!resetn) begin
      state_q  <= S_IDLE;
      e_q      <= '0;
      i_q      <= '0;
      t_nz_q   <= 1'b0;
      acc_q    <= '0;
      xt_q     <= '0;
      result   <= '0;
      done     <= 1'b0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      i_q      <= i_d;
      t_nz_q   <= t_nz_d;
      acc_q    <= acc_d;
      xt_q     <= xt_d;
      result   <= result_d;
      done     <= done_d;
      mm_start <= mm_start_d;
      mm_a     <= mm_a_d;
      mm_b     <= mm_b_d;
      mm_m     <= mm_m_d;
    end
  end

endmodule

// File: tb/tb_montgomery_exp.sv
// Self-checking bench for montgomery_exp: a behavioural Montgomery multiplier
// with configurable latency answers the handshake, a plain square-and-multiply
// reference gives expected results, and directed sequences cover restart,
// start-with-done and mid-run reset.
module tb_montgomery_exp;

  localparam int N      = 1024;
  localparam int E_BITS = 1024;
  localparam int T_W    = 11;

  typedef logic [N-1:0]      word_t;
  typedef logic [E_BITS-1:0] exp_t;

  typedef struct {
    string          name;
    word_t          x;
    exp_t           e;
    logic [T_W-1:0] t;
    word_t          m;
    word_t          res;
    int             starts;
  } vec_t;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  word_t          in_x = '0;
  exp_t           in_e = '0;
  logic [T_W-1:0] in_t = '0;
  word_t          in_m = '0;
  word_t          in_r = '0;
  word_t          in_r2 = '0;
  word_t          result;
  logic           done;
  logic           mm_start;
  word_t          mm_a, mm_b, mm_m;
  word_t          mm_result = '0;
  logic           mm_done = 1'b0;

  montgomery_exp #(.N(N), .E_BITS(E_BITS), .T_W(T_W)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_t(in_t), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .result(result), .done(done), .mm_start(mm_start),
    .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    n_mmstart = 0;
  int    n_done = 0;
  int    proto_err = 0;
  bit    rand_lat = 1'b0;
  word_t cur_m = '0;

  task automatic check(input string name, input word_t act, input word_t exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h (low 64 bits)", name, act[63:0], exp_v[63:0]);
    end
  endtask

  // Montgomery product a*b*2^-N mod m, bit-serial reduction.
  function automatic word_t mont(input word_t a, input word_t b, input word_t m);
    logic [2*N+1:0] u, mw, aw, bw;
    aw = {{(N+2){1'b0}}, a};
    bw = {{(N+2){1'b0}}, b};
    mw = {{(N+2){1'b0}}, m};
    u  = aw * bw;
    for (int k = 0; k < N; k++) begin
      if (u[0]) u = u + mw;
      u = u >> 1;
    end
    if (u >= mw) u = u - mw;
    return u[N-1:0];
  endfunction

  function automatic word_t calc_r(input word_t m);
    logic [2*N+1:0] p, mw, q;
    p    = '0;
    p[N] = 1'b1;
    mw   = {{(N+2){1'b0}}, m};
    q    = p % mw;
    return q[N-1:0];
  endfunction

  function automatic word_t calc_r2(input word_t m);
    logic [2*N+1:0] r, mw, q;
    r  = {{(N+2){1'b0}}, calc_r(m)};
    mw = {{(N+2){1'b0}}, m};
    q  = (r * r) % mw;
    return q[N-1:0];
  endfunction

  // Reference x^e mod m with ordinary modular arithmetic.
  function automatic word_t ref_exp(input word_t x, input exp_t e, input int t, input word_t m);
    logic [2*N-1:0] acc, mw, xw;
    mw  = {{N{1'b0}}, m};
    xw  = {{N{1'b0}}, x};
    acc = {{(2*N-1){1'b0}}, 1'b1} % mw;
    for (int i = t - 1; i >= 0; i--) begin
      acc = (acc * acc) % mw;
      if (e[i]) acc = (acc * xw) % mw;
    end
    return acc[N-1:0];
  endfunction

  function automatic int popc(input exp_t e, input int t);
    int c = 0;
    for (int i = 0; i < t; i++) if (e[i]) c++;
    return c;
  endfunction

  function automatic word_t rand_word();
    word_t v;
    for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Multiplier model and protocol monitor.
  bit    busy = 1'b0;
  bit    track = 1'b0;
  int    cnt = 0;
  word_t cap_a, cap_b, cap_m, res_q;
  logic  mm_done_d1 = 1'b0;
  logic  rst_q = 1'b0;

  always @(posedge clk) begin
    mm_done_d1 <= mm_done;
    rst_q      <= !resetn;
  end

  always @(negedge clk) begin
    if (rst_q) track = 1'b0;
    // After a completion exactly one of next launch or done must follow.
    if (track && mm_done_d1 && (mm_start == done)) proto_err++;
    mm_done = 1'b0;
    if (busy) begin
      if (track && (mm_a !== cap_a || mm_b !== cap_b || mm_m !== cap_m)) proto_err++;
      cnt--;
      if (cnt == 0) begin
        mm_done   = 1'b1;
        mm_result = res_q;
        busy      = 1'b0;
      end
    end
    if (mm_start) begin
      if (busy) proto_err++;
      if (mm_m !== cur_m) proto_err++;
      cap_a = mm_a;
      cap_b = mm_b;
      cap_m = mm_m;
      res_q = mont(mm_a, mm_b, mm_m);
      cnt   = rand_lat ? int'($urandom_range(20, 1)) : 5;
      busy  = 1'b1;
      track = 1'b1;
      n_mmstart++;
    end
    if (done) n_done++;
  end

  task automatic begin_run(input string tag, input word_t x, input exp_t e,
                           input logic [T_W-1:0] t, input word_t m);
    @(negedge clk);
    in_x  = x;
    in_e  = e;
    in_t  = t;
    in_m  = m;
    in_r  = calc_r(m);
    in_r2 = calc_r2(m);
    cur_m = m;
    start = 1'b1;
    n_mmstart = 0;
    n_done    = 0;
    proto_err = 0;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_first_mm_start"}, N'(mm_start), N'(1));
  endtask

  task automatic wait_done(input int budget, output word_t res, output bit seen);
    seen = 1'b0;
    res  = '0;
    for (int c = 0; c < budget; c++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        res  = result;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_run(input string tag, input word_t exp_res, input int exp_starts,
                            input int budget);
    word_t res;
    bit    seen;
    wait_done(budget, res, seen);
    check({tag, "_done_seen"}, N'(seen), N'(1));
    check({tag, "_result"}, res, exp_res);
    repeat (3) @(negedge clk);
    check({tag, "_mm_starts"}, N'(n_mmstart), N'(exp_starts));
    check({tag, "_done_pulses"}, N'(n_done), N'(1));
    check({tag, "_protocol"}, N'(proto_err), N'(0));
    check({tag, "_result_hold"}, result, exp_res);
  endtask

  function automatic vec_t mk(input string nm, input word_t x, input exp_t e,
                              input logic [T_W-1:0] t, input word_t m,
                              input word_t res, input int st);
    vec_t v;
    v.name = nm; v.x = x; v.e = e; v.t = t; v.m = m; v.res = res; v.starts = st;
    return v;
  endfunction

  vec_t  vecs[7];
  exp_t  e_hi;
  word_t res_w, m_w, x_w, exp_w;
  exp_t  e_w;
  bit    seen_w;
  int    t_w, st_w;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    e_hi      = '1;
    e_hi[2:0] = 3'b101;
    vecs[0] = mk("x3_e5",     N'(3), E_BITS'(5),  T_W'(3),    N'(13), N'(9), 7);
    vecs[1] = mk("x2_e15",    N'(2), E_BITS'(15), T_W'(4),    N'(13), N'(8), 10);
    vecs[2] = mk("t0",        N'(7), E_BITS'(0),  T_W'(0),    N'(13), N'(1), 2);
    vecs[3] = mk("t1",        N'(5), E_BITS'(1),  T_W'(1),    N'(13), N'(5), 4);
    vecs[4] = mk("hi_bits",   N'(3), e_hi,        T_W'(3),    N'(13), N'(9), 7);
    vecs[5] = mk("x0",        N'(0), E_BITS'(5),  T_W'(3),    N'(13), N'(0), 7);
    vecs[6] = mk("t_sat",     N'(3), E_BITS'(5),  T_W'(2000), N'(13), N'(9), 1028);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_result", result, N'(0));
    check("rst_done", N'(done), N'(0));
    check("rst_mm_start", N'(mm_start), N'(0));
    check("rst_mm_a", mm_a, N'(0));
    check("rst_mm_m", mm_m, N'(0));
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table, fixed latency.
    rand_lat = 1'b0;
    for (int v = 0; v < 7; v++) begin
      begin_run(vecs[v].name, vecs[v].x, vecs[v].e, vecs[v].t, vecs[v].m);
      finish_run(vecs[v].name, vecs[v].res, vecs[v].starts, vecs[v].starts * 7 + 20);
    end

    // Start re-pulsed mid-run with different operands is ignored.
    begin_run("restart", N'(3), E_BITS'(5), T_W'(3), N'(13));
    repeat (3) @(negedge clk);
    in_x = N'(5);
    in_e = E_BITS'(7);
    in_m = N'(11);
    in_r = calc_r(N'(11));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_run("restart", N'(9), 7, 100);

    // Start coincident with done is ignored.
    begin_run("start_at_done", N'(3), E_BITS'(5), T_W'(3), N'(13));
    wait_done(100, res_w, seen_w);
    check("start_at_done_seen", N'(seen_w), N'(1));
    check("start_at_done_result", res_w, N'(9));
    in_x  = N'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_at_done_no_launch", N'(mm_start), N'(0));
    repeat (10) @(negedge clk);
    check("start_at_done_mm_starts", N'(n_mmstart), N'(7));
    check("start_at_done_done_pulses", N'(n_done), N'(1));
    check("start_at_done_result_hold", result, N'(9));

    // Reset while a SQUARE multiplication is outstanding.
    begin_run("abort", N'(3), E_BITS'(5), T_W'(3), N'(13));
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("abort_result", result, N'(0));
    check("abort_done", N'(done), N'(0));
    check("abort_mm_start", N'(mm_start), N'(0));
    check("abort_mm_a", mm_a, N'(0));
    check("abort_mm_b", mm_b, N'(0));
    check("abort_mm_m", mm_m, N'(0));
    repeat (12) @(negedge clk);
    check("abort_no_new_launch", N'(n_mmstart), N'(2));
    check("abort_no_done", N'(n_done), N'(0));
    begin_run("after_abort", N'(2), E_BITS'(15), T_W'(4), N'(13));
    finish_run("after_abort", N'(8), 10, 100);

    // Random full-width operands with random multiplier latency.
    rand_lat = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_w        = rand_word();
      m_w[N-1]   = 1'b1;
      m_w[0]     = 1'b1;
      x_w        = rand_word() % m_w;
      for (int j = 0; j < E_BITS / 32; j++) e_w[j*32 +: 32] = $urandom;
      t_w        = (k == 0) ? E_BITS : int'($urandom_range(48, 1));
      exp_w      = ref_exp(x_w, e_w, t_w, m_w);
      st_w       = 2 + t_w + popc(e_w, t_w);
      begin_run($sformatf("rand%0d", k), x_w, e_w, T_W'(t_w), m_w);
      finish_run($sformatf("rand%0d", k), exp_w, st_w, st_w * 22 + 20);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/montgomery_exp.md
MONTGOMERY_EXP -- requirements
Module: montgomery_exp

Interface
REQ-001 Parameter N, default 1024, operand/modulus width in bits.
REQ-002 Parameter E_BITS, default 1024, maximum exponent width in bits.
REQ-003 Parameter T_W, default 11, width of the exponent-length input; it SHALL hold values 0..E_BITS.
REQ-004 Port clk, input, 1, single clock; all logic rising-edge.
REQ-005 Port resetn, input, 1, reset, synchronous, active-low.
REQ-006 Port start, input, 1, one-cycle request to begin exponentiation.
REQ-007 Port in_x, input, N, base, in_x < in_m.
REQ-008 Port in_e, input, E_BITS, exponent.
REQ-009 Port in_t, input, T_W, exponent bit length; bits in_e[in_t-1:0] are processed MSB first.
REQ-010 Port in_m, input, N, odd modulus.
REQ-011 Port in_r, input, N, 2^N mod in_m.
REQ-012 Port in_r2, input, N, 2^(2N) mod in_m.
REQ-013 Port result, output, N, in_x^e mod in_m.
REQ-014 Port done, output, 1, one-cycle pulse when result is valid.
REQ-015 Port mm_start, output, 1, one-cycle start pulse to the montgomery multiplier.
REQ-016 Ports mm_a, mm_b, mm_m, output, N each, multiplier operands.
REQ-017 Port mm_result, input, N, multiplier result.
REQ-018 Port mm_done, input, 1, multiplier completion, valid in the cycle it is high.

Function
REQ-019 On a cycle with start=1 in IDLE, the block SHALL register in_x, in_e, in_t, in_m, in_r, in_r2; later input changes SHALL have no effect.
REQ-020 States: IDLE, TOMONT, SQUARE, MULT, FROMMONT; each non-IDLE state performs exactly one multiplication.
REQ-021 TOMONT: xt = MM(x, r2); accumulator A loaded with r; bit index i = t-1; next SQUARE if t>0, else FROMMONT.
REQ-022 SQUARE: A = MM(A, A); next MULT if e[i]=1; otherwise, if i>0, decrement i and stay in SQUARE, else go to FROMMONT.
REQ-023 MULT: A = MM(A, xt); then, if i>0, decrement i and go to SQUARE, else go to FROMMONT.
REQ-024 FROMMONT: A = MM(A, 1); on completion, result <= mm_result, assert done, return to IDLE.
REQ-025 Handshake: mm_start SHALL be high for exactly one cycle, the first cycle of each multiplication state.
REQ-026 mm_a, mm_b, mm_m SHALL be stable from the mm_start cycle until mm_done is sampled.
REQ-027 mm_m SHALL always equal the registered modulus.
REQ-028 mm_result SHALL be captured only in a cycle with mm_done=1; the state transition SHALL occur on that same edge.
REQ-029 mm_done arriving outside a waiting state SHALL be ignored.
REQ-030 Timing: first mm_start in the cycle after start is sampled; each subsequent mm_start in the cycle after the previous mm_done.
REQ-031 done SHALL be high in the cycle after the final mm_done; result SHALL hold until the next accepted start.
REQ-032 Multiplication count SHALL equal 2 + t + popcount(e[t-1:0]).
REQ-033 start while not IDLE SHALL be ignored; a start coincident with done SHALL be ignored.
REQ-034 in_t > E_BITS is saturated to E_BITS; in_t = 0 yields result 1 mod m.
REQ-035 Bits of in_e at or above in_t are ignored.

Reset
REQ-036 While resetn=0 at a clock edge: state IDLE; result=0; done=0; mm_start=0; mm_a=mm_b=mm_m=0; all internal registers zero.
REQ-037 Reset mid-operation SHALL abort immediately; a stale mm_done after reset SHALL be ignored; no done pulse.

Verification (behavioural multiplier model, latency 5 cycles, N=1024)
REQ-038 x=3, e=5, t=3, m=13 -> result=9; 7 mm_start pulses; done exactly 1 pulse.
REQ-039 x=2, e=15, t=4, m=13 -> result=8; 10 mm_start pulses.
REQ-040 x=7, e=0, t=0, m=13 -> result=1; 2 mm_start pulses.
REQ-041 start re-pulsed mid-run with different in_x -> ignored; first result unchanged.
REQ-042 resetn low during SQUARE for 1 cycle -> outputs zero, IDLE; a new start then completes correctly.
REQ-043 Multiplier latency randomised 1..20 per operation, 1024-bit random x, e, odd m -> result equals a reference modular exponentiation; mm operands stable while waiting.
